// File: rtl/ppd.sv
`default_nettype none
// ============================================================================
// Module   : ppd
// Purpose  : Streaming prefix-difference unit. It recovers per-lane element
//            values from beats of lane-parallel running totals.
// Revision : 1.0 - initial release
// ============================================================================
module ppd #(
   parameter int NW = 5,
   parameter int IW = 6,
   parameter int OW = 4,
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_sum [1<<NW],
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data [1<<NW],
   output logic          out_last,
   output logic          out_ovf,
   output logic [BW-1:0] out_beat
);

   localparam int N = 1 << NW;

   logic [IW-1:0] d [N];
   logic          accept;
   logic          ovf;

   logic          out_valid_q, out_valid_d;
   logic [OW-1:0] out_data_q [N];
   logic [OW-1:0] out_data_d [N];
   logic          out_last_q, out_last_d;
   logic          out_ovf_q, out_ovf_d;
   logic [BW-1:0] out_beat_q, out_beat_d;
   logic [IW-1:0] carry_q, carry_d;
   logic [BW-1:0] cnt_q, cnt_d;

   // Lane differences; lane 0 subtracts the last total of the previous beat.
   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      d[0]     = in_sum[0] - carry_q;
      for (int i = 1; i < N; i++) begin
         d[i] = in_sum[i] - in_sum[i-1];
      end
      ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         ovf = ovf | ((d[i] >> OW) != '0);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ovf_d   = out_ovf_q;
      out_beat_d  = out_beat_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         for (int i = 0; i < N; i++) begin
            out_data_d[i] = d[i][OW-1:0];
         end
         out_last_d = in_last;
         out_ovf_d  = ovf;
         out_beat_d = cnt_q;
         if (in_last) begin
            carry_d = '0;
            cnt_d   = '0;
         end else begin
            carry_d = in_sum[N-1];
            cnt_d   = cnt_q + BW'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            out_data_q[i] <= '0;
         end
         out_last_q <= 1'b0;
         out_ovf_q  <= 1'b0;
         out_beat_q <= '0;
         carry_q    <= '0;
         cnt_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ovf_q   <= out_ovf_d;
         out_beat_q  <= out_beat_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;
   assign out_beat  = out_beat_q;

endmodule
`default_nettype wire

// File: doc/ppd.md
Name: ppd

Overview:
- Streaming inverse of the lane-parallel prefix-sum unit (prefix difference).
- Accepts beats of N running totals and recovers the N per-lane element values.
- Carries the last running total of each beat into the next beat of the same frame.
- Sits on the decode side of the EAU datapath, after the storage/transport stage and before the consumer of per-element counts.

Parameters:
- NW, 5, log2 of lane count; N = 1 << NW lanes per beat.
- IW, 6, width of each incoming running total (prefix sum); arithmetic is modulo 2^IW.
- OW, 4, width of each recovered element value; IW >= OW is required.
- BW, 8, width of the per-frame beat index counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_sum  input  IW x N (unpacked array [N])  running totals, lane 0 first.
- in_last  input  1  beat is the final beat of a frame.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  OW x N (unpacked array [N])  recovered element values.
- out_last  output  1  registered copy of in_last.
- out_ovf  output  1  at least one lane difference does not fit in OW bits.
- out_beat  output  BW  index of this beat within its frame (0 = first).

Behaviour:
- Difference rule, computed on the accepted beat, all modulo 2^IW:
  - d[0] = in_sum[0] - carry.
  - d[i] = in_sum[i] - in_sum[i-1], for i = 1..N-1.
- Output mapping:
  - out_data[i] = d[i][OW-1:0].
  - out_ovf = OR over lanes of (d[i][IW-1:OW] != 0); constant 0 when IW == OW.
- Carry register, IW bits:
  - Holds in_sum[N-1] of the previous accepted beat in the current frame.
  - Accepting a beat with in_last=0 loads in_sum[N-1].
  - Accepting a beat with in_last=1 loads 0, so the next frame starts fresh.
- Beat counter, BW bits:
  - out_beat is captured from the counter on acceptance.
  - Counter increments on each accepted non-last beat and clears to 0 on an accepted last beat.
  - Wraps modulo 2^BW without affecting the data path.
- Pipeline and handshake:
  - Single registered output stage; latency is 1 cycle from acceptance to out_valid.
  - in_ready = !out_valid || out_ready (combinational; full throughput when downstream is always ready).
  - Output register loads on acceptance.
  - out_valid stays set and all out_* fields stay stable while out_valid && !out_ready.
  - out_valid clears when the beat is consumed and no new beat is accepted in the same cycle.
- Simultaneous events: out_ready and in_valid in the same cycle with out_valid=1 gives a consume-and-load; no bubble, no duplicated beat.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0; carry and counter are frozen.
- Reset (any cycle, including mid-frame):
  - Cleared: out_valid=0, out_data all 0, out_last=0, out_ovf=0, out_beat=0, carry=0, counter=0.
  - Any held output beat is discarded.
  - in_ready=1 in the cycle after reset deasserts.
  - A partially received frame is abandoned; the next accepted beat is treated as beat 0 of a new frame.
- Inputs are not sampled while rst=1.

Test Plan:
Bench uses NW=2 (N=4), IW=6, OW=4, BW=8.
- Single-beat frame: in_sum={1,3,6,10}, last=1, out_ready=1 -> one cycle later out_data={1,2,3,4}, out_ovf=0, out_last=1, out_beat=0; carry returns to 0.
- Two-beat frame: {2,2,5,9} last=0, then {9,15,16,20} last=1 -> outputs {2,0,3,4} beat 0, then {0,6,1,4} beat 1 out_last=1; a following {3,3,3,3} last=1 yields {3,0,0,0}, proving the carry cleared.
- Wrap and overflow: within a frame, carry=60 (prior beat lane 3 = 60), then in_sum={2,5,5,40} -> d0=6 (64-60+2), outputs {6,3,0,3}, out_ovf=1 because d3=35 (0b100011) does not fit in OW bits.
- Backpressure: three back-to-back valid beats with out_ready held 0 for 3 cycles -> first output held stable, in_ready=0, carry and counter unchanged; releasing out_ready delivers all three beats in order with out_beat 0,1,2 and no gaps.
- Reset mid-frame: accept {1,2,3,4} last=0, assert rst one cycle while out_valid=1 -> out_valid=0 and out_beat=0; then {1,2,3,4} yields {1,1,1,1} with out_beat=0.
- Counter wrap: 257 consecutive non-last beats -> out_beat sequence 0..255,0 with correct data throughout.
